// File: rtl/display_bcd_conv_pkg.sv
// ============================================================================
// display_pkg : shared types and constants for the display BCD converter
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package display_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ABS    = 2'd1,
        SHIFT  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam int BCD_DIGITS      = 3;
    localparam int MAG_BITS        = 10;
    localparam int SHIFT_COUNT     = 10;
    localparam int DEFAULT_MAX_MAG = 999;

endpackage

`default_nettype wire

// File: rtl/display_bcd_conv_bcd_add3.sv
// ============================================================================
// bcd_add3 : double-dabble digit correction (digit >= 5 gets +3)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_add3 (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

`default_nettype wire

// File: rtl/display_bcd_conv.sv
// ============================================================================
// display_bcd_conv : signed tenths value to 3-digit BCD plus sign/saturation,
//                    one double-dabble shift per clock behind valid/ready
// Revision         : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_bcd_conv
    import display_pkg::*;
#(
    parameter int WIDTH   = 12,
    parameter int MAX_MAG = DEFAULT_MAX_MAG
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_value,
    output logic [3:0]       num2,
    output logic [3:0]       num1,
    output logic [3:0]       num0,
    output logic             neg,
    output logic             sat,
    output logic             done
);

    state_t                      state_q;
    logic [WIDTH-1:0]            value_q;
    logic [MAG_BITS-1:0]         mag_q;
    logic [4*BCD_DIGITS-1:0]     bcd_q;
    logic [3:0]                  cnt_q;
    logic                        sign_q;
    logic                        sat_q;

    logic [WIDTH-1:0]            w_abs;
    logic                        w_over;
    logic [4*BCD_DIGITS-1:0]     w_bcd_adj;
    logic [4*BCD_DIGITS-1:0]     bcd_d;

    // Unsigned negation keeps -2^(WIDTH-1) representable as 2^(WIDTH-1).
    assign w_abs  = value_q[WIDTH-1] ? (-value_q) : value_q;
    assign w_over = (w_abs > WIDTH'(MAX_MAG));

    generate
        for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_digit
            bcd_add3 u_add3 (
                .digit_i (bcd_q[4*g +: 4]),
                .digit_o (w_bcd_adj[4*g +: 4])
            );
        end
    endgenerate

    assign bcd_d    = {w_bcd_adj[4*BCD_DIGITS-2:0], mag_q[MAG_BITS-1]};
    assign in_ready = (state_q == IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            value_q <= '0;
            mag_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            sat_q   <= 1'b0;
            num2    <= '0;
            num1    <= '0;
            num0    <= '0;
            neg     <= 1'b0;
            sat     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        value_q <= in_value;
                        state_q <= ABS;
                    end
                end
                ABS: begin
                    mag_q   <= w_over ? MAG_BITS'(MAX_MAG) : w_abs[MAG_BITS-1:0];
                    sat_q   <= w_over;
                    sign_q  <= value_q[WIDTH-1];
                    bcd_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    bcd_q <= bcd_d;
                    mag_q <= {mag_q[MAG_BITS-2:0], 1'b0};
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'(SHIFT_COUNT - 1))
                        state_q <= COMMIT;
                end
                COMMIT: begin
                    num2    <= bcd_q[11:8];
                    num1    <= bcd_q[7:4];
                    num0    <= bcd_q[3:0];
                    neg     <= sign_q;
                    sat     <= sat_q;
                    done    <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_display_bcd_conv.sv
// ============================================================================
// tb_display_bcd_conv : directed bench with a per-cycle reference model
// Revision            : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_display_bcd_conv;

    localparam int WIDTH = 12;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_value = '0;
    logic [3:0]       num2, num1, num0;
    logic             neg, sat, done;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    display_bcd_conv #(.WIDTH(WIDTH), .MAX_MAG(999)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_value (in_value),
        .num2     (num2),
        .num1     (num1),
        .num0     (num0),
        .neg      (neg),
        .sat      (sat),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Result packed as {sat, neg, hundreds, tens, units}.
    function automatic logic [13:0] model(input int v);
        int m;
        bit s;
        m = (v < 0) ? -v : v;
        s = (m > 999);
        if (s) m = 999;
        return {s, (v < 0), 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a conversion is a 12-edge delay after acceptance.
    logic [13:0] m_out = '0;
    logic [13:0] m_pend = '0;
    logic        m_done = 1'b0;
    int          m_busy = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_out  <= '0;
            m_done <= 1'b0;
            m_busy <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy > 0) begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) begin
                    m_out  <= m_pend;
                    m_done <= 1'b1;
                end
            end else if (in_valid) begin
                m_pend <= model(int'($signed(in_value)));
                m_busy <= 12;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_out", int'({sat, neg, num2, num1, num0}), int'(m_out));
            check("cyc_done", int'(done), int'(m_done));
            check("cyc_ready", int'(in_ready), int'(m_busy == 0));
        end
    end

    task automatic wait_ready();
        int k;
        for (k = 0; k < 30 && !in_ready; k++) @(negedge clk);
        if (!in_ready) check("ready_timeout", 0, 1);
    endtask

    // Accept v, then require done exactly 13 negedges after the driving one.
    task automatic convert(input int v, input int e2, input int e1, input int e0,
                           input bit en, input bit es);
        int lat;
        wait_ready();
        in_valid = 1'b1;
        in_value = WIDTH'(v);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) in_valid = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
        end
        check("latency", lat, 13);
        check("lit_digits", int'({num2, num1, num0}), (e2 << 8) | (e1 << 4) | e0);
        check("lit_neg", int'(neg), int'(en));
        check("lit_sat", int'(sat), int'(es));
        check("lit_ready", int'(in_ready), 1);
    endtask

    initial begin
        check("pin_model_123", int'(model(123)), int'({1'b0, 1'b0, 4'd1, 4'd2, 4'd3}));
        check("pin_model_m45", int'(model(-45)), int'({1'b0, 1'b1, 4'd0, 4'd4, 4'd5}));
        check("pin_model_m2048", int'(model(-2048)), int'({1'b1, 1'b1, 4'd9, 4'd9, 4'd9}));

        repeat (3) @(negedge clk);
        check("rst_out", int'({sat, neg, num2, num1, num0, done}), 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_ready", int'(in_ready), 1);

        convert(0,     0, 0, 0, 0, 0);
        convert(123,   1, 2, 3, 0, 0);
        convert(-45,   0, 4, 5, 1, 0);
        convert(999,   9, 9, 9, 0, 0);
        convert(1000,  9, 9, 9, 0, 1);
        convert(-2048, 9, 9, 9, 1, 1);
        convert(-1000, 9, 9, 9, 1, 1);
        convert(7,     0, 0, 7, 0, 0);

        // 555 held valid while busy must be dropped, then accepted once idle.
        wait_ready();
        in_valid = 1'b1;
        in_value = WIDTH'(321);
        @(negedge clk);
        in_value = WIDTH'(555);
        repeat (12) @(negedge clk);
        check("ign_done", int'(done), 1);
        check("ign_digits", int'({num2, num1, num0}), 12'h321);
        @(negedge clk);
        in_valid = 1'b0;
        check("ign_hold", int'({num2, num1, num0}), 12'h321);
        repeat (12) @(negedge clk);
        check("second_done", int'(done), 1);
        check("second_digits", int'({num2, num1, num0}), 12'h555);

        // Reset in the middle of SHIFT aborts with zeroed outputs.
        wait_ready();
        in_valid = 1'b1;
        in_value = WIDTH'(678);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_out", int'({sat, neg, num2, num1, num0, done}), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            check("abort_nodone", int'(done), 0);
        end
        check("abort_ready", int'(in_ready), 1);
        convert(42, 0, 4, 2, 0, 0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/display_bcd_conv.md
Name: display_bcd_conv

Overview:
- Sequential signed-binary to 3-digit BCD converter; sits directly upstream of the display digit multiplexer.
- Drives that multiplexer's three digit inputs (hundreds, tens, units) and its negative-sign input.
- Input is a signed value in tenths, e.g. a dB level. The display places the decimal point after the tens digit, so 123 reads "12.3".
- Uses iterative double-dabble, one shift per clock, behind a valid/ready handshake.
- Outputs hold the last completed result, so the scanned display never shows partial values.

Parameters:
- WIDTH, 12, bit width of the signed input value; legal values are WIDTH >= 11.
- MAX_MAG, 999, largest displayable magnitude; larger magnitudes saturate to this.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  value present on in_value
- in_ready  output  1  converter idle and able to accept a value
- in_value  input  WIDTH  signed two's-complement value in tenths
- num2  output  4  BCD hundreds digit
- num1  output  4  BCD tens digit (decimal point follows it on the display)
- num0  output  4  BCD units digit
- neg  output  1  result is negative
- sat  output  1  last result was clipped to MAX_MAG
- done  output  1  one-cycle pulse: num2/num1/num0/neg/sat just updated

Behaviour:
- Reset (asynchronous, active-low):
  - num2/num1/num0 = 0, neg = 0, sat = 0, done = 0.
  - FSM returns to IDLE, so in_ready = 1 once reset_n is high.
  - Asserting reset mid-conversion aborts the conversion. No done pulse is issued and the outputs read 0.
- FSM states: IDLE, ABS, SHIFT, COMMIT.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid=1, capture in_value and go to ABS.
- ABS (1 cycle):
  - Compute the magnitude of the captured value.
  - If the magnitude exceeds MAX_MAG, load MAX_MAG and set the sat flag; otherwise load the magnitude into a 10-bit shift register.
  - Sign flag = input MSB. Value 0 gives sign 0.
  - The most negative input (-2^(WIDTH-1)) must not overflow: it saturates with neg=1.
  - Clear the 12-bit BCD accumulator and the 4-bit shift count. Go to SHIFT.
- SHIFT (exactly 10 cycles):
  - Each cycle, every BCD digit >= 5 gets +3.
  - Then {BCD, magnitude} shifts left by one and the count increments.
  - After the 10th shift, go to COMMIT.
- COMMIT (1 cycle):
  - On the edge leaving COMMIT, register num2/num1/num0, neg and sat together.
  - Also set done=1 for exactly one cycle and return to IDLE.
- Latency: accept edge E0 leads to done=1 and new outputs during the cycle after edge E12. Throughput is one conversion per 13 cycles.
- in_ready is low in ABS, SHIFT and COMMIT. in_valid in those states is ignored; the value is not queued.
- in_value must be stable only at the accept edge.
- Outputs change only at COMMIT and hold between conversions.
- Every BCD digit at COMMIT is 0..9.

Decomposition:
- Package display_pkg:
  - state enum type (IDLE, ABS, SHIFT, COMMIT)
  - BCD_DIGITS = 3, MAG_BITS = 10, SHIFT_COUNT = 10, DEFAULT_MAX_MAG = 999
- One natural sub-module, bcd_add3: combinational 4-bit digit correction (if >= 5 then +3). Instantiate it 3 times in the SHIFT datapath.

Test Plan:
- Reset, then in_value=0 accepted → after 12 edges done pulses once; num2/num1/num0=0/0/0, neg=0, sat=0; in_ready high again in the same cycle.
- in_value=123 → 1/2/3, neg=0, sat=0. in_value=-45 → 0/4/5, neg=1, sat=0. in_value=999 → 9/9/9, sat=0.
- in_value=1000 → 9/9/9, sat=1, neg=0. in_value=-2048 (WIDTH=12) → 9/9/9, neg=1, sat=1.
- Accept 321, then drive in_valid=1 with in_value=555 for the next 12 cycles:
  - The second value is ignored; done pulses once with 3/2/1.
  - Outputs stay 3/2/1 until 555 is accepted in IDLE.
- Accept 678, assert reset_n=0 during SHIFT:
  - Outputs go 0 immediately and no done pulse occurs.
  - After release, in_ready=1 and a fresh conversion of 42 gives 0/4/2.
